// File: rtl/ldpc_enc_pkg.sv
// ldpc_enc_pkg
// Shared constants and the FSM state type for the LDPC encoder controller.
//   ROW_W         : width of one generator row / parity accumulator (bits)
//   BYTE_W        : message / parity byte width
//   BYTES_PER_BLK : message bytes per generator row
//   ADDR_W        : generator ROM row address width
package ldpc_enc_pkg;
   localparam int ROW_W         = 256;
   localparam int BYTE_W        = 8;
   localparam int BYTES_PER_BLK = 32;
   localparam int ADDR_W        = 5;
   localparam int BYT_W         = $clog2(BYTES_PER_BLK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;
endpackage

// File: rtl/ldpc_parity_ser.sv
// ldpc_parity_ser
// Serialises the 256-bit parity accumulator into 32 bytes, LSB byte first,
// over a valid/ready stream.
//   clk, rst  : clock, synchronous active-high reset
//   active    : controller is in its drain phase
//   l_acc     : parity accumulator (held constant while draining)
//   m_ready   : downstream accepts the current byte
//   m_valid, m_data, m_last : parity byte stream
//   done      : final byte handed off this cycle
module ldpc_parity_ser
   import ldpc_enc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic [ROW_W-1:0]  l_acc,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_last,
   output logic              done
);
   logic [BYT_W-1:0] obyt;
   logic             last_byte;

   assign last_byte = (obyt == BYT_W'(BYTES_PER_BLK - 1));

   // obyt wraps naturally to 0 after the final byte, ready for the next frame
   always_ff @(posedge clk) begin
      if (rst)                     obyt <= '0;
      else if (active && m_ready)  obyt <= obyt + BYT_W'(1);
   end

   // Accumulator and obyt only move on a handshake, so data/last are stable
   // under back-pressure without extra holding registers.
   assign m_valid = active;
   assign m_data  = l_acc[{obyt, 3'b000} +: BYTE_W];
   assign m_last  = active & last_byte;
   assign done    = active & m_ready & last_byte;
endmodule

// File: rtl/ldpc_encode_ctrl.sv
// ldpc_encode_ctrl
// Controller for a parallel-cell LDPC encoder: sequences the generator
// buffer (load/rotate), streams message bytes into the cells, accumulates
// parity and drains it as 32 bytes.
//   clk, rst                         : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last    : message byte stream in
//   d_in, rst_c, en_G, load_G, en_L,
//   addrROM                          : cell array / generator buffer control
//   L_cell / L_in                    : parity state out / next parity in
//   m_valid/m_ready/m_data/m_last    : parity byte stream out
//   busy                             : frame in progress
//   err_len                          : framing error pulse
// Config macro: LDPC_ENC_LEN_CHECK_EN -- when defined, err_len flags an
// s_last that disagrees with the counter-derived frame end; otherwise
// s_last is ignored and err_len is 0.
module ldpc_encode_ctrl
   import ldpc_enc_pkg::*;
#(
   parameter int NBLK = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_last,
   output logic [BYTE_W-1:0] d_in,
   output logic              rst_c,
   output logic              en_G,
   output logic              load_G,
   output logic              en_L,
   output logic [ADDR_W-1:0] addrROM,
   output logic [ROW_W-1:0]  L_cell,
   input  logic [ROW_W-1:0]  L_in,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              err_len
);
   localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NBLK - 1);
   localparam logic [BYT_W-1:0]  LAST_BYT = BYT_W'(BYTES_PER_BLK - 1);

   state_t             state;
   logic [ADDR_W-1:0]  blk;
   logic [BYT_W-1:0]   byt;
   logic [ROW_W-1:0]   l_acc;
   logic               hs, blk_end, last_blk, next_row, ser_done;

   assign hs       = s_valid & s_ready;
   assign blk_end  = (byt == LAST_BYT);
   assign last_blk = (blk == LAST_BLK);
   // Final byte of a non-final block: fetch the next generator row in the
   // same cycle the cells consume that byte with the current row.
   assign next_row = hs & blk_end & ~last_blk;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         blk     <= '0;
         byt     <= '0;
         l_acc   <= '0;
         s_ready <= 1'b0;
         busy    <= 1'b0;
         rst_c   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               blk   <= '0;
               byt   <= '0;
               l_acc <= '0;
               if (s_valid) begin
                  state <= LOAD;
                  busy  <= 1'b1;
                  rst_c <= 1'b1;
               end
            end
            LOAD: begin
               state   <= RUN;
               s_ready <= 1'b1;
            end
            RUN: begin
               if (hs) begin
                  l_acc <= L_in;
                  if (blk_end) begin
                     byt <= '0;
                     if (last_blk) begin
                        state   <= DRAIN;
                        s_ready <= 1'b0;
                     end else begin
                        blk <= blk + ADDR_W'(1);
                     end
                  end else begin
                     byt <= byt + BYT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (ser_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  rst_c <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign d_in    = s_ready ? s_data : '0;
   assign en_L    = hs;
   assign en_G    = (state == LOAD) | hs;
   assign load_G  = (state == LOAD) | next_row;
   assign addrROM = next_row ? blk + ADDR_W'(1) : blk;
   assign L_cell  = l_acc;

`ifdef LDPC_ENC_LEN_CHECK_EN
   assign err_len = hs & (s_last != (last_blk & blk_end));
`else
   logic unused_s_last;
   assign unused_s_last = s_last;
   assign err_len       = 1'b0;
`endif

   ldpc_parity_ser u_ser (
      .clk     (clk),
      .rst     (rst),
      .active  (state == DRAIN),
      .l_acc   (l_acc),
      .m_ready (m_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .done    (ser_done)
   );
endmodule

// File: tb/tb_ldpc_encode_ctrl.sv
// tb_ldpc_encode_ctrl
// Bench for ldpc_encode_ctrl: a small cell-array emulation (generator buffer
// that loads/rotates by one byte per message byte, parity = L ^ (row & byte))
// and a frame-level reference model computing parity directly from the
// message and ROM.
module tb_ldpc_encode_ctrl;
   localparam int NB = 32;
   localparam int FB = NB * 32;

   logic         clk = 0;
   logic         rst = 1;
   logic         s_valid = 0, s_last = 0, m_ready = 1;
   logic [7:0]   s_data = 0;
   logic         s_ready, rst_c, en_G, load_G, en_L, m_valid, m_last, busy, err_len;
   logic [7:0]   d_in, m_data;
   logic [4:0]   addrROM;
   logic [255:0] L_cell, L_in;

   int checks = 0, errors = 0;

   ldpc_encode_ctrl #(.NBLK(NB)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .d_in(d_in), .rst_c(rst_c), .en_G(en_G), .load_G(load_G),
      .en_L(en_L), .addrROM(addrROM), .L_cell(L_cell), .L_in(L_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   // ---------------- cell array emulation ----------------
   logic [255:0] rom [NB];
   logic [255:0] gbuf;
   assign L_in = L_cell ^ (gbuf & {32{d_in}});
   always @(posedge clk) begin
      if (!rst_c)     gbuf <= '0;
      else if (en_G)  gbuf <= load_G ? rom[addrROM] : {gbuf[247:0], gbuf[255:248]};
   end

   // ---------------- stimulus data + reference model ----------------
   logic [7:0] msg   [FB];
   logic       lastv [FB];

   function automatic logic [255:0] model_parity();
      logic [255:0] p, row, rot;
      int sh;
      p = '0;
      for (int i = 0; i < FB; i++) begin
         row = rom[i / 32];
         sh  = 8 * (i % 32);
         rot = (sh == 0) ? row : ((row << sh) | (row >> (256 - sh)));
         p   = p ^ (rot & {32{msg[i]}});
      end
      return p;
   endfunction

   // ---------------- monitor (samples 1 time unit before posedge) ----------------
   int         hs_cnt, run_cyc, mval_cnt;
   int         load_idx[$], load_adr[$], err_idx[$];
   logic [7:0] out_q[$];
   logic       outl_q[$];

   always begin
      @(negedge clk);
      #4;
      if (s_valid && s_ready) begin
         if (load_G) begin load_idx.push_back(hs_cnt); load_adr.push_back(int'(addrROM)); end
         if (err_len) err_idx.push_back(hs_cnt);
         hs_cnt++;
      end
      if (s_ready) run_cyc++;
      if (m_valid) mval_cnt++;
      if (m_valid && m_ready) begin out_q.push_back(m_data); outl_q.push_back(m_last); end
   end

   task automatic clear_mon();
      hs_cnt = 0; run_cyc = 0; mval_cnt = 0;
      load_idx.delete(); load_adr.delete(); err_idx.delete();
      out_q.delete(); outl_q.delete();
   endtask

   task automatic fill_msg(input int kind);
      for (int i = 0; i < FB; i++) begin
         msg[i]   = (kind == 0) ? 8'h00 : (kind == 1) ? ((i == 0) ? 8'h01 : 8'h00) : 8'($urandom);
         lastv[i] = (i == FB - 1);
      end
   endtask

   // Drives one frame; abort_at >= 0 pulses rst before that byte is sent.
   task automatic drive_frame(input int pct, input int abort_at);
      int i = 0, guard = 0;
      while (i < FB && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (abort_at >= 0 && i == abort_at) begin
            s_valid = 0; rst = 1;
            @(negedge clk); @(negedge clk);
            rst = 0;
            return;
         end
         s_valid = ($urandom_range(99) < pct);
         s_data  = msg[i];
         s_last  = lastv[i];
         if (s_valid && s_ready) i++;
      end
      @(negedge clk);
      s_valid = 0; s_last = 0;
      checks++;
      if (i != FB) begin errors++; $display("FAIL drive_timeout sent=%0d required=%0d", i, FB); end
   endtask

   // Collects 32 parity bytes; optional 10-cycle stall once m_valid rises.
   task automatic collect(input bit stall, output logic [255:0] got);
      int guard = 0;
      logic [7:0] d0;
      logic l0;
      if (stall) begin
         while (!m_valid && guard < 5000) begin @(negedge clk); guard++; end
         d0 = m_data; l0 = m_last;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (m_data !== d0 || m_last !== l0 || m_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_stable cyc=%0d data=%02h/%0b required=%02h/%0b", c, m_data, m_last, d0, l0);
            end
         end
         m_ready = 1;
      end
      guard = 0;
      while (out_q.size() < 32 && guard < 5000) begin @(negedge clk); guard++; end
      checks++;
      if (out_q.size() != 32) begin
         errors++; $display("FAIL out_count got=%0d required=32", out_q.size());
         got = 'x;
      end else begin
         for (int k = 0; k < 32; k++) got[8*k +: 8] = out_q[k];
         for (int k = 0; k < 32; k++) begin
            checks++;
            if (outl_q[k] !== (k == 31)) begin
               errors++; $display("FAIL m_last byte=%0d got=%0b required=%0b", k, outl_q[k], (k == 31));
            end
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_parity(input string nm, input logic [255:0] got);
      logic [255:0] exp;
      exp = model_parity();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h required=%h", nm, got, exp); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; s_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_ready, m_valid, m_last, en_G, load_G, en_L, rst_c, busy, err_len} !== 9'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b required=000000000",
                            {s_ready, m_valid, m_last, en_G, load_G, en_L, rst_c, busy, err_len});
      end
      checks++;
      if (addrROM !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d required=0", addrROM); end
      checks++;
      if (L_cell !== '0) begin errors++; $display("FAIL reset_L got=%h required=0", L_cell); end
      rst = 0;
      @(negedge clk);
      checks++;
      if ({s_ready, m_valid, busy, rst_c} !== 4'b0) begin
         errors++; $display("FAIL reset_after got=%b required=0000", {s_ready, m_valid, busy, rst_c});
      end
   endtask

   task automatic test_zero_frame();
      logic [255:0] got;
      fill_msg(0); clear_mon(); m_ready = 1;
      drive_frame(100, -1);
      collect(0, got);
      checks++;
      if (got !== '0) begin errors++; $display("FAIL zero_parity got=%h required=0", got); end
      checks++;
      if (run_cyc != FB) begin errors++; $display("FAIL zero_run_cycles got=%0d required=%0d", run_cyc, FB); end
      checks++;
      if (err_idx.size() != 0) begin errors++; $display("FAIL zero_err_len got=%0d required=0", err_idx.size()); end
   endtask

   task automatic test_single_one();
      logic [255:0] got;
      fill_msg(1); clear_mon(); m_ready = 1;
      drive_frame(100, -1);
      collect(0, got);
      check_parity("single_parity", got);
      checks++;
      if (load_idx.size() != NB - 1) begin
         errors++; $display("FAIL load_count got=%0d required=%0d", load_idx.size(), NB - 1);
      end else begin
         for (int k = 0; k < NB - 1; k++) begin
            checks++;
            if (load_idx[k] != 32 * k + 31 || load_adr[k] != k + 1) begin
               errors++; $display("FAIL load_pos k=%0d got=%0d/%0d required=%0d/%0d",
                                  k, load_idx[k], load_adr[k], 32 * k + 31, k + 1);
            end
         end
      end
   endtask

   task automatic test_random_stall();
      logic [255:0] got;
      fill_msg(2); clear_mon(); m_ready = 0;
      drive_frame(50, -1);
      collect(1, got);
      check_parity("stall_parity", got);
   endtask

   task automatic test_len_err();
      logic [255:0] got;
      fill_msg(2); lastv[500] = 1; lastv[FB - 1] = 0;
      clear_mon(); m_ready = 1;
      drive_frame(80, -1);
      collect(0, got);
      check_parity("lenerr_parity", got);
`ifdef LDPC_ENC_LEN_CHECK_EN
      checks++;
      if (err_idx.size() != 2 || err_idx[0] != 500 || err_idx[1] != FB - 1) begin
         errors++; $display("FAIL err_len_pos count=%0d required=2 at 500,1023", err_idx.size());
      end
`else
      checks++;
      if (err_idx.size() != 0) begin errors++; $display("FAIL err_len_off got=%0d required=0", err_idx.size()); end
`endif
   endtask

   task automatic test_abort();
      logic [255:0] got;
      fill_msg(2); clear_mon(); m_ready = 1;
      drive_frame(100, 700);
      repeat (40) @(negedge clk);
      checks++;
      if (mval_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_quiet m_valid_cycles=%0d busy=%0b required=0/0", mval_cnt, busy);
      end
      fill_msg(2); clear_mon();
      drive_frame(70, -1);
      collect(0, got);
      check_parity("abort_next_parity", got);
   endtask

   initial begin
      for (int r = 0; r < NB; r++)
         for (int w = 0; w < 8; w++) rom[r][32*w +: 32] = $urandom;
      test_reset();
      test_zero_frame();
      test_single_one();
      test_random_stall();
      test_len_err();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
